interrupt_controller: RTL

Sequences the 2A03 CPU core's interrupt entry: synchronises /NMI and /IRQ, latches NMI edges, decides at instruction boundaries whether to hijack the next opcode fetch, and drives `interrupt_flag` into the instruction controller so it loads BRK (0x00) instead of the fetched opcode. During the forced-BRK sequence it selects the vector low byte, suppresses stack writes for RESET, and handles NMI hijack of an in-flight IRQ. It sits between the external pins, the decode/timing logic and the instruction controller.

---
 rtl/interrupt_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer for the 2A03 core: synchronises /NMI and /IRQ,
// latches NMI edges, and forces a BRK through the instruction controller for
// NMI, IRQ and RESET, including NMI hijack of an in-flight IRQ sequence.
module interrupt_controller (
   input  logic       sys_clock,
   input  logic       rst,
   input  logic       clk_phase_1,
   input  logic       nmi_n,
   input  logic       irq_n,
   input  logic       i_flag,
   input  logic       poll,
   input  logic [2:0] next_cycle,
   input  logic [2:0] cycle,
   input  logic       vector_done,
   output logic       interrupt_flag,
   output logic       is_hw_interrupt,
   output logic       suppress_writes,
   output logic [7:0] vector_lo,
   output logic       nmi_pending
);

   typedef enum logic [1:0] {
      StIdle,
      StPending,
      StService
   } state_e;

   typedef enum logic [1:0] {
      SrcNone,
      SrcIrq,
      SrcNmi,
      SrcReset
   } source_e;

   logic    r_nmi_s1;
   logic    r_nmi_s2;
   logic    r_irq_s1;
   logic    r_irq_s2;
   logic    r_nmi_prev;
   logic    r_nmi_pending;
   state_e  r_state;
   source_e r_source;

   state_e  w_state_next;
   source_e w_source_next;
   logic    w_nmi_edge;
   logic    w_nmi_clear;
   logic    w_irq_active;

   // Pin synchronisers run on every sys_clock, independent of the phase enable.
   always_ff @(posedge sys_clock or negedge rst) begin
      if (!rst) begin
         r_nmi_s1 <= 1'b1;
         r_nmi_s2 <= 1'b1;
         r_irq_s1 <= 1'b1;
         r_irq_s2 <= 1'b1;
      end else begin
         r_nmi_s1 <= nmi_n;
         r_nmi_s2 <= r_nmi_s1;
         r_irq_s1 <= irq_n;
         r_irq_s2 <= r_irq_s1;
      end
   end

   assign w_nmi_edge   = r_nmi_prev & ~r_nmi_s2;
   assign w_irq_active = ~r_irq_s2 & ~i_flag;

   // Next-state decode; vector_done takes priority over a late hijack.
   always_comb begin
      w_state_next  = r_state;
      w_source_next = r_source;
      w_nmi_clear   = 1'b0;
      case (r_state)
         StIdle: begin
            if (poll) begin
               if (r_nmi_pending) begin
                  w_source_next = SrcNmi;
                  w_state_next  = StPending;
               end else if (w_irq_active) begin
                  w_source_next = SrcIrq;
                  w_state_next  = StPending;
               end
            end
         end
         StPending: begin
            if (next_cycle == 3'd1) begin
               w_state_next = StService;
            end
         end
         StService: begin
            if (vector_done) begin
               w_nmi_clear   = (r_source == SrcNmi);
               w_state_next  = StIdle;
               w_source_next = SrcNone;
            end else if ((r_source == SrcIrq) && r_nmi_pending && (cycle <= 3'd4)) begin
               w_source_next = SrcNmi;
            end
         end
         default: begin
            w_state_next  = StPending;
            w_source_next = SrcReset;
         end
      endcase
   end

   // Phase-1 state update; a fresh NMI edge wins over a same-cycle clear.
   always_ff @(posedge sys_clock or negedge rst) begin
      if (!rst) begin
         r_state       <= StPending;
         r_source      <= SrcReset;
         r_nmi_prev    <= 1'b1;
         r_nmi_pending <= 1'b0;
      end else if (clk_phase_1) begin
         r_state    <= w_state_next;
         r_source   <= w_source_next;
         r_nmi_prev <= r_nmi_s2;
         if (w_nmi_edge) begin
            r_nmi_pending <= 1'b1;
         end else if (w_nmi_clear) begin
            r_nmi_pending <= 1'b0;
         end
      end
   end

   // Outputs decode purely from registered state.
   always_comb begin
      interrupt_flag  = (r_state == StPending);
      is_hw_interrupt = (r_state != StIdle);
      suppress_writes = (r_source == SrcReset);
      nmi_pending     = r_nmi_pending;
      case (r_source)
         SrcNmi:   vector_lo = 8'hFA;
         SrcReset: vector_lo = 8'hFC;
         default:  vector_lo = 8'hFE;
      endcase
   end

endmodule
